// File: rtl/regbank_arbiter.sv
// Two-requester write arbiter in front of a four-entry register bank with a registered read port.
// A grant commits its write one cycle after it is taken; clr_all wipes the bank and holds any grant.
module regbank_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req0,
    input  logic [1:0]       addr0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [1:0]       addr1,
    input  logic [WIDTH-1:0] d1,
    input  logic             clr_all,
    input  logic [1:0]       raddr,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] bank_q [4];
    logic [WIDTH-1:0] bank_d [4];
    logic [WIDTH-1:0] q_q, q_d;
    logic             commit0, commit1;

    always_comb begin
        // A grant is frozen, not lost, while clr_all is high.
        commit0 = (state_q == GNT0) && !clr_all;
        commit1 = (state_q == GNT1) && !clr_all;
        state_d = state_q;
        prio_d  = prio_q;
        bank_d  = bank_q;
        q_d     = bank_q[raddr];

        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !prio_q)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (commit0) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end
            GNT1: begin
                if (commit1) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_all) begin
            for (int i = 0; i < 4; i++) begin
                bank_d[i] = '0;
            end
        end else if (commit0) begin
            bank_d[addr0] = d0;
        end else if (commit1) begin
            bank_d[addr1] = d1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            q_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            q_q     <= q_d;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // An edge carrying clear aborts the grant, so it must not be acknowledged.
    assign ack0 = commit0 && !clear;
    assign ack1 = commit1 && !clear;
    assign busy = (state_q != IDLE);
    assign q    = q_q;

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of each bank register and of d0, d1 and q.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 clear  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req0  input  1  SHALL be requester 0 write request; held high until ack0.
REQ-005 addr0  input  2  SHALL be requester 0 target register index, held stable while req0 high.
REQ-006 d0  input  WIDTH  SHALL be requester 0 write data, held stable while req0 high.
REQ-007 req1, addr1 (2), d1 (WIDTH)  inputs  SHALL be requester 1 equivalents of REQ-004..006.
REQ-008 clr_all  input  1  SHALL zero all four bank registers synchronously without resetting the arbiter.
REQ-009 raddr  input  2  SHALL be the read index.
REQ-010 ack0, ack1  output  1 each  SHALL be one-cycle pulses marking the cycle the requester's write is committed.
REQ-011 busy  output  1  SHALL be high while the FSM is in a grant state.
REQ-012 q  output  WIDTH  SHALL be registered read data for raddr.

Function
REQ-013 Bank SHALL be four WIDTH-bit registers, index 0..3, internal to the block.
REQ-014 FSM states: IDLE, GNT0, GNT1; encoding free.
REQ-015 IDLE: neither req high -> stay IDLE; only req0 -> GNT0; only req1 -> GNT1; both -> grant the requester named by pointer prio.
REQ-016 prio SHALL be 1 bit, reset 0 (requester 0 first); after each committed write it SHALL point to the other requester.
REQ-017 GNT0/GNT1: write d[n] into bank[addr[n]], pulse ack[n] this cycle, return to IDLE next cycle.
REQ-018 Throughput: at most one write per two cycles; request-to-commit latency two edges from IDLE when uncontended.
REQ-019 A requester SHALL drop req the cycle after ack; a req still high in IDLE is treated as a new request.
REQ-020 ack0 and ack1 SHALL never be high together; no ack outside GNT states.
REQ-021 clr_all high in IDLE: bank zeroed next edge; FSM arbitrates normally the same cycle.
REQ-022 clr_all high in GNT state: bank zeroed, pending write NOT committed, no ack, FSM stays in the same GNT state, prio unchanged; write commits on first cycle clr_all low.
REQ-023 Request dropped while in GNT state (protocol violation): write still committed with current addr/d, ack still pulsed.
REQ-024 q SHALL update each edge to bank[raddr] as it was before that edge (read-before-write; one-cycle latency).
REQ-025 clr_all and write never both affect bank in one cycle; clr_all has priority.
REQ-026 No arithmetic; indices 0..3 fully decoded, no wrap or out-of-range case.

Reset
REQ-027 clear high at an edge SHALL force: FSM IDLE, prio 0, bank all zero, q 0, ack0 0, ack1 0, busy 0.
REQ-028 clear SHALL override all other inputs, including clr_all and in-progress grants; aborted write not committed, no ack.
REQ-029 First edge with clear low SHALL arbitrate normally.

Verification
REQ-030 Reset then req0=1, addr0=2, d0=4'hA -> ack0 pulses on 2nd edge, busy high that cycle; raddr=2 -> q=4'hA one edge later.
REQ-031 After reset req0 and req1 together (addr0=0,d0=4'h3; addr1=1,d1=4'h5) -> ack0 first, ack1 two cycles later; bank[0]=3, bank[1]=5.
REQ-032 Continuous req0 and req1 for 8 cycles -> acks alternate 0,1,0,1, one per two cycles, never simultaneous.
REQ-033 req1 granted (addr1=3,d1=4'hF), clr_all high that GNT1 cycle for 2 cycles -> no ack, bank all 0, then ack1 and bank[3]=4'hF.
REQ-034 clear asserted during GNT0 -> no ack0, bank[addr0] stays 0, FSM IDLE, prio 0, q 0.
REQ-035 raddr=1 with write to index 1 (4'h0 -> 4'h7) committing same edge -> q=4'h0 that edge, 4'h7 next edge.
